turbo_interleaver: RTL and testbench

LTE turbo-encoder internal interleaver (QPP, 3GPP TS 36.212 §5.1.3.2.3). It accepts one CRC-attached code block as a byte stream, buffers it, and streams out the bit-permuted block as bytes under output backpressure. It sits between the CRC-attach stage (upstream, `vld_crc`/`rdy_crc`) and the turbo constituent encoders (downstream, `vld_out`/`rdy_out`).

---
 rtl/turbo_interleaver_pkg.sv | 30 +++
 rtl/turbo_interleaver_if.sv | 7 +
 rtl/turbo_interleaver_qpp_index_gen.sv | 38 +++
 rtl/turbo_interleaver.sv | 73 +++++++
 tb/tb_turbo_interleaver.sv | 131 +++++++++++++
 5 files changed

// File: rtl/turbo_interleaver_pkg.sv
// turbo_interleaver_pkg: QPP interleaver constants, state enum and modular-add helper.
// Define TURBO_INTLV_CBS6144_EN to support K=6144 blocks alongside K=1056.
package turbo_intlv_pkg;
  localparam int IW = 13;
  typedef logic [IW-1:0] idx_t;
  localparam idx_t K_S = 13'd1056;
  localparam idx_t F1_S = 13'd17;
  localparam idx_t F2_S = 13'd66;
  localparam idx_t K_L = 13'd6144;
  localparam idx_t F1_L = 13'd263;
  localparam idx_t F2_L = 13'd480;
  localparam int NB_S = 132;
  localparam int NB_L = 768;
`ifdef TURBO_INTLV_CBS6144_EN
  localparam logic CBS_EN = 1'b1;
  localparam int KMAX = 6144;
`else
  localparam logic CBS_EN = 1'b0;
  localparam int KMAX = 1056;
`endif
  localparam int AW = $clog2(KMAX);
  typedef enum logic [1:0] {IDLE, SETUP, LOAD, OUT} state_t;
  // Both operands are below k, so one conditional subtract reduces the sum.
  function automatic idx_t add_mod(idx_t a, idx_t b, idx_t k);
    logic [IW:0] s, d;
    s = {1'b0, a} + {1'b0, b};
    d = s - {1'b0, k};
    return d[IW] ? s[IW-1:0] : d[IW-1:0];
  endfunction
endpackage

// File: rtl/turbo_interleaver_if.sv
// turbo_interleaver_if: block input strobe/data and byte output handshake.
interface turbo_interleaver_if;
  logic vld_crc, rdy_crc, cbs, rdy_out, vld_out, last_byte;
  logic [7:0] data_in, data_out;
  modport master (output vld_crc, cbs, data_in, rdy_out, input rdy_crc, vld_out, last_byte, data_out);
  modport slave (input vld_crc, cbs, data_in, rdy_out, output rdy_crc, vld_out, last_byte, data_out);
endinterface

// File: rtl/turbo_interleaver_qpp_index_gen.sv
// qpp_index_gen: produces eight consecutive QPP indices per step via the Pi/g recurrence.
module qpp_index_gen
  import turbo_intlv_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic init,
  input  logic step,
  input  idx_t k,
  input  idx_t f1,
  input  idx_t f2,
  output idx_t idx [8]
);
  idx_t pi, g, f2x2;
  idx_t ps [9];
  idx_t gs [9];
  assign f2x2 = add_mod(f2, f2, k);
  always_comb begin
    ps[0] = pi;
    gs[0] = g;
    for (int i = 0; i < 8; i++) begin
      ps[i+1] = add_mod(ps[i], gs[i], k);
      gs[i+1] = add_mod(gs[i], f2x2, k);
      idx[i] = ps[i];
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pi <= '0;
      g <= '0;
    end else if (init) begin
      pi <= '0;
      g <= add_mod(f1, f2, k);
    end else if (step) begin
      pi <= ps[8];
      g <= gs[8];
    end
endmodule

// File: rtl/turbo_interleaver.sv
// turbo_interleaver: buffers one code block and streams it out QPP-permuted, a byte at a time.
module turbo_interleaver
  import turbo_intlv_pkg::*;
(
  input logic clk,
  input logic reset,
  turbo_interleaver_if.slave io
);
  state_t state;
  logic big, vld, last;
  logic [9:0] cnt, last_cnt;
  logic [KMAX-1:0] mem;
  logic [AW-1:0] wa;
  logic [7:0] dout;
  idx_t k, f1, f2;
  idx_t idx [8];
  assign k = big ? K_L : K_S;
  assign f1 = big ? F1_L : F1_S;
  assign f2 = big ? F2_L : F2_S;
  assign last_cnt = big ? 10'(NB_L - 1) : 10'(NB_S - 1);
  assign wa = AW'({cnt, 3'b000});
  assign io.rdy_crc = state == IDLE;
  assign io.vld_out = vld;
  assign io.last_byte = last;
  assign io.data_out = vld ? dout : 8'h00;
  qpp_index_gen u_gen (
    .clk(clk), .reset(reset), .init(state == SETUP), .step(vld && io.rdy_out),
    .k(k), .f1(f1), .f2(f2), .idx(idx)
  );
  // Read is combinational so the byte captured on the final load edge is already visible for byte 0.
  always_comb begin
    dout = '0;
    for (int i = 0; i < 8; i++) dout[i] = mem[AW'(idx[i])];
  end
  always_ff @(posedge clk)
    if (state == LOAD) mem[wa +: 8] <= io.data_in;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      big <= 1'b0;
      cnt <= '0;
      vld <= 1'b0;
      last <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.vld_crc) begin
          big <= io.cbs & CBS_EN;
          state <= SETUP;
        end
        SETUP: begin
          cnt <= '0;
          state <= LOAD;
        end
        LOAD: begin
          cnt <= cnt == last_cnt ? '0 : cnt + 10'd1;
          if (cnt == last_cnt) begin
            state <= OUT;
            vld <= 1'b1;
          end
        end
        OUT: if (io.rdy_out) begin
          cnt <= cnt + 10'd1;
          last <= cnt + 10'd1 == last_cnt;
          if (cnt == last_cnt) begin
            state <= IDLE;
            vld <= 1'b0;
            last <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_turbo_interleaver.sv
// tb_turbo_interleaver: randomized blocks against a direct Pi(i)=(f1*i+f2*i^2) mod K model, scoreboard-checked.
module tb_turbo_interleaver;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  turbo_interleaver_if io();
  turbo_interleaver dut (.clk(clk), .reset(reset), .io(io));
  bit blk [6144];
  logic [8:0] sb [$];
  logic [7:0] obytes [768];
  int ocnt, nchk, npass;
  logic pstall = 1'b0;
  logic [8:0] pout, e;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask
  function automatic int pi_ref(int i, int kk, int f1, int f2);
    longint v = (longint'(f1) * i + longint'(f2) * i * i) % kk;
    return int'(v);
  endfunction
  always @(negedge clk) begin
    if (!io.vld_out) chk("idle_zero", {io.last_byte, io.data_out}, 0);
    else begin
      if (pstall) chk("hold", {io.last_byte, io.data_out}, pout);
      if (io.rdy_out) begin
        if (sb.size() == 0) begin
          nchk++;
          $display("FAIL extra_byte: got 0x%0h with empty scoreboard", io.data_out);
        end else begin
          e = sb.pop_front();
          chk("byte", {io.last_byte, io.data_out}, e);
          if (ocnt < 768) obytes[ocnt] = io.data_out;
          ocnt++;
        end
      end
    end
    pstall = io.vld_out && !io.rdy_out;
    pout = {io.last_byte, io.data_out};
  end
  task automatic fill(input bit rnd, input int one);
    for (int i = 0; i < 6144; i++) blk[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    if (one >= 0) blk[one] = 1'b1;
  endtask
  // mode 0: rdy_out high, 1: random stalls, 2: two-cycle stall, 3: reset abort mid-stream
  task automatic run(input int kk, input int mode, input bit pulse);
    int nb, f1, f2, t;
    logic [7:0] bv;
    nb = kk / 8;
    f1 = kk == 6144 ? 263 : 17;
    f2 = kk == 6144 ? 480 : 66;
    for (int n = 0; n < nb; n++) begin
      for (int b = 0; b < 8; b++) bv[b] = blk[pi_ref(8 * n + b, kk, f1, f2)];
      sb.push_back({n == nb - 1, bv});
    end
    ocnt = 0;
    io.vld_crc = 1'b1;
    io.cbs = kk == 6144;
    @(posedge clk); #1;
    io.vld_crc = 1'b0;
    @(posedge clk); #1;
    for (int n = 0; n < nb; n++) begin
      for (int b = 0; b < 8; b++) io.data_in[b] = blk[8 * n + b];
      io.vld_crc = pulse && n == 10;
      if (n == nb - 1) chk("vld_early", io.vld_out, 0);
      @(posedge clk); #1;
    end
    io.vld_crc = 1'b0;
    chk("vld_rise", io.vld_out, 1);
    t = 0;
    while (sb.size() != 0 && t < 20000) begin
      if (mode == 3 && t == 20) begin
        reset = 1'b0;
        #1;
        chk("abort", {io.rdy_crc, io.vld_out, io.last_byte, io.data_out}, 11'h400);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        break;
      end
      io.rdy_out = mode == 1 ? ($urandom_range(0, 3) != 0) : mode == 2 ? !(t == 40 || t == 41) : 1'b1;
      @(posedge clk); #1;
      t++;
    end
    io.rdy_out = 1'b1;
    if (t >= 20000) chk("timeout", sb.size(), 0);
    if (mode == 0) chk("out_cycles", t, nb);
    chk("idle_after", {io.rdy_crc, io.vld_out}, 2'b10);
  endtask
  initial begin
    io.vld_crc = 1'b0;
    io.cbs = 1'b0;
    io.data_in = '0;
    io.rdy_out = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst", {io.rdy_crc, io.vld_out, io.last_byte, io.data_out}, 11'h400);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_rst", io.rdy_crc, 1);
    fill(0, 83);
    run(1056, 0, 0);
    chk("bit83_b0", obytes[0], 8'h02);
    chk("bit83_b1", obytes[1], 8'h00);
    fill(0, 0);
    run(1056, 0, 0);
    chk("bit0_b0", obytes[0], 8'h01);
    fill(0, 49);
    run(1056, 0, 0);
    chk("bit49_b131", obytes[131], 8'h80);
    fill(1, -1);
    run(1056, 1, 1);
    fill(1, -1);
    run(1056, 2, 0);
    fill(1, -1);
    run(1056, 3, 0);
    fill(1, -1);
    run(1056, 0, 0);
`ifdef TURBO_INTLV_CBS6144_EN
    fill(0, 743);
    run(6144, 0, 0);
    chk("bit743_b0", obytes[0], 8'h02);
    fill(1, -1);
    run(6144, 1, 0);
`endif
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
